bus_arbiter_4: RTL

- Round-robin arbiter that shares one 8-bit datapath bus among 4 requesters.
- Drives the 2-bit select of the existing 8-bit 4:1 mux.
- Registers the selected byte onto the bus with a valid flag.
- Sits between the register file/ALU sources and the processor's internal bus, so that only one source owns the bus at a time.
- Guarantees one dead cycle between owners and bounds how long any owner may hold the bus.

---
 rtl/bus_arbiter_4_pkg.sv | 23 ++
 rtl/mux_4to1_8bit.sv | 16 +
 rtl/bus_arbiter_4.sv | 116 +++++++++++
 3 files changed

// File: rtl/bus_arbiter_4_pkg.sv
// bus_arbiter_4_pkg: shared state encoding, default hold limit and requester indices
package bus_arbiter_4_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        HANDOFF = 2'd2
    } state_t;

    localparam int MAX_HOLD_DEF = 4;

    localparam logic [1:0] REQ0 = 2'd0;
    localparam logic [1:0] REQ1 = 2'd1;
    localparam logic [1:0] REQ2 = 2'd2;
    localparam logic [1:0] REQ3 = 2'd3;

    function automatic logic [3:0] onehot(input logic [1:0] idx);
        return (idx == REQ0) ? 4'b0001 :
               (idx == REQ1) ? 4'b0010 :
               (idx == REQ2) ? 4'b0100 : 4'b1000;
    endfunction

endpackage

// File: rtl/mux_4to1_8bit.sv
// mux_4to1_8bit: 8-bit 4:1 data selector steered by S
module mux_4to1_8bit (
    input  logic [7:0] i1,
    input  logic [7:0] i2,
    input  logic [7:0] i3,
    input  logic [7:0] i4,
    input  logic [1:0] S,
    output logic [7:0] Y
);

    // pick one of the four sources by index
    always_comb begin
        Y = (S == 2'd0) ? i1 : (S == 2'd1) ? i2 : (S == 2'd2) ? i3 : i4;
    end

endmodule

// File: rtl/bus_arbiter_4.sv
// bus_arbiter_4: round-robin owner of the shared 8-bit bus; BUS_ARB_LOCK_EN adds a lock input that suppresses hold-limit preemption
module bus_arbiter_4
    import bus_arbiter_4_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEF,
    parameter int HOLD_W   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic [7:0] i1,
    input  logic [7:0] i2,
    input  logic [7:0] i3,
    input  logic [7:0] i4,
`ifdef BUS_ARB_LOCK_EN
    input  logic       lock,
`endif
    output logic [3:0] grant,
    output logic [1:0] sel,
    output logic [7:0] bus_q,
    output logic       bus_valid
);

    state_t              r_state;
    logic   [HOLD_W-1:0] r_hold_cnt;
    logic   [1:0]        r_last;

    state_t              w_state;
    logic   [3:0]        w_grant;
    logic   [1:0]        w_sel;
    logic   [HOLD_W-1:0] w_cnt;
    logic   [1:0]        w_last;
    logic   [2:0]        w_pick;
    logic                w_sat;
    logic                w_release;
    logic                w_lock;
    logic   [7:0]        w_mux;

`ifdef BUS_ARB_LOCK_EN
    assign w_lock = lock;
`else
    assign w_lock = 1'b0;
`endif

    // first asserted request searching last+1, last+2, last+3, last; msb flags a winner
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
        logic [2:0] pick;
        logic [1:0] k;
        pick = 3'b000;
        for (int i = 4; i >= 1; i--) begin
            k = last + 2'(i);
            if (r[k]) pick = {1'b1, k};
        end
        return pick;
    endfunction

    mux_4to1_8bit u_mux (
        .i1 (i1),
        .i2 (i2),
        .i3 (i3),
        .i4 (i4),
        .S  (sel),
        .Y  (w_mux)
    );

    // next owner, grant and hold count; IDLE and HANDOFF both arbitrate
    always_comb begin
        w_state   = r_state;
        w_grant   = grant;
        w_sel     = sel;
        w_cnt     = r_hold_cnt;
        w_last    = r_last;
        w_pick    = rr_pick(req, r_last);
        w_sat     = r_hold_cnt == HOLD_W'(MAX_HOLD);
        w_release = !req[sel] || (w_sat && |(req & ~grant) && !w_lock);
        if (r_state == BUSY) begin
            if (w_release) begin
                w_state = HANDOFF;
                w_grant = '0;
                w_last  = sel;
            end else begin
                w_cnt = w_sat ? r_hold_cnt : r_hold_cnt + 1'b1;
            end
        end else if (w_pick[2]) begin
            w_state = BUSY;
            w_grant = onehot(w_pick[1:0]);
            w_sel   = w_pick[1:0];
            w_cnt   = HOLD_W'(1);
        end else begin
            w_state = IDLE;
            w_grant = '0;
        end
    end

    // arbitration state plus the registered bus byte, which follows the owner one cycle late
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            grant      <= '0;
            sel        <= REQ0;
            r_hold_cnt <= '0;
            r_last     <= REQ3;
            bus_q      <= '0;
            bus_valid  <= 1'b0;
        end else begin
            r_state    <= w_state;
            grant      <= w_grant;
            sel        <= w_sel;
            r_hold_cnt <= w_cnt;
            r_last     <= w_last;
            bus_q      <= (r_state == BUSY) ? w_mux : bus_q;
            bus_valid  <= r_state == BUSY;
        end
    end

endmodule
